// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready load and one-word holding buffer
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;
    logic             ld;
    logic [WIDTH-1:0] ld_word;
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction
    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction
    assign load_ready = ~hold_full;
    assign busy       = so_valid | hold_full;
    assign accept     = load_valid & ~hold_full;
    assign last_bit   = cnt == CW'(WIDTH - 1);
    // a queued word takes priority over din on the last-bit edge, which gives back-to-back streaming
    assign ld_word    = hold_full ? hold : din;
    assign ld         = (state == IDLE) ? accept : (last_bit & (hold_full | load_valid));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            so        <= 1'b0;
            so_valid  <= 1'b0;
            so_last   <= 1'b0;
        end else begin
            if (ld) begin
                sh       <= adv(ld_word);
                so       <= first_bit(ld_word);
                so_valid <= 1'b1;
                so_last  <= 1'b0;
                cnt      <= '0;
                state    <= SHIFT;
            end else if (state == SHIFT && !last_bit) begin
                sh      <= adv(sh);
                so      <= first_bit(sh);
                so_last <= cnt == CW'(WIDTH - 2);
                cnt     <= cnt + CW'(1);
            end else begin
                so       <= 1'b0;
                so_valid <= 1'b0;
                so_last  <= 1'b0;
                state    <= IDLE;
            end
            if (state == SHIFT && last_bit && hold_full) begin
                hold_full <= 1'b0;
            end else if (state == SHIFT && !last_bit && accept) begin
                hold      <= din;
                hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of the serializer (default and 8-bit MSB-first) with a SIPO loopback
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       lv;
    logic       rdy, so, sv, sl, bsy;
    logic [7:0] din8;
    logic       lv8;
    logic       rdy8, so8, sv8, sl8, bsy8;
    logic [3:0] q;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    piso_serializer dut (
        .clk(clk), .rst(rst), .din(din), .load_valid(lv), .load_ready(rdy),
        .so(so), .so_valid(sv), .so_last(sl), .busy(bsy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst(rst), .din(din8), .load_valid(lv8), .load_ready(rdy8),
        .so(so8), .so_valid(sv8), .so_last(sl8), .busy(bsy8)
    );

    // downstream 4-bit serial-in parallel-out register fed by so
    always_ff @(posedge clk) q <= {so, q[3:1]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_so"}, so, 0);
        chk({tag, "_so_valid"}, sv, 0);
        chk({tag, "_so_last"}, sl, 0);
        chk({tag, "_busy"}, bsy, 0);
        chk({tag, "_load_ready"}, rdy, 1);
    endtask

    task automatic chk_bit(input string tag, input logic e_so, input logic e_last, input logic e_rdy);
        chk({tag, "_so_valid"}, sv, 1);
        chk({tag, "_so"}, so, e_so);
        chk({tag, "_so_last"}, sl, e_last);
        chk({tag, "_load_ready"}, rdy, e_rdy);
        chk({tag, "_busy"}, bsy, 1);
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] r;
        int         k;
        rst = 1'b1; lv = 1'b0; din = '0; lv8 = 1'b0; din8 = '0;
        #1;
        chk_idle("rst_async");
        repeat (2) begin
            @(negedge clk);
            chk_idle("rst_hold");
        end
        chk("rst8_ready", rdy8, 1);
        chk("rst8_busy", bsy8, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("rst_release");

        // single word 1011, din changed after capture
        din = 4'b1011; lv = 1'b1;
        @(negedge clk);
        lv = 1'b0; din = 4'b0000;
        e = 8'b00001011;
        for (int i = 0; i < 4; i++) begin
            chk_bit("single", e[i], i == 3, 1'b1);
            @(negedge clk);
        end
        chk_idle("single_end");

        // back-to-back A then 3 via holding buffer
        din = 4'hA; lv = 1'b1;
        @(negedge clk);
        e = 8'b00111010;
        r = 8'b11110001;
        for (int i = 0; i < 8; i++) begin
            chk_bit("b2b", e[i], i == 3 || i == 7, r[i]);
            if (i == 0) din = 4'h3;
            if (i == 1) begin lv = 1'b0; din = 4'h0; end
            @(negedge clk);
        end
        chk_idle("b2b_end");

        // 5 then F loaded exactly on the last-bit edge
        din = 4'h5; lv = 1'b1;
        @(negedge clk);
        e = 8'b11110101;
        for (int i = 0; i < 8; i++) begin
            chk_bit("lastedge", e[i], i == 3 || i == 7, 1'b1);
            if (i == 0) lv = 1'b0;
            if (i == 3) begin lv = 1'b1; din = 4'hF; end
            if (i == 4) lv = 1'b0;
            @(negedge clk);
        end
        chk_idle("lastedge_end");

        // asynchronous reset mid-word
        din = 4'hC; lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        @(negedge clk);
        chk("midrst_pre_valid", sv, 1);
        rst = 1'b1;
        #1;
        chk("midrst_so_valid", sv, 0);
        chk("midrst_busy", bsy, 0);
        chk("midrst_so", so, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midrst_release");
        din = 4'h6; lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        e = 8'b00000110;
        for (int i = 0; i < 4; i++) begin
            chk_bit("after_rst", e[i], i == 3, 1'b1);
            @(negedge clk);
        end
        chk_idle("after_rst_end");

        // 8-bit MSB-first, C5
        din8 = 8'hC5; lv8 = 1'b1;
        @(negedge clk);
        lv8 = 1'b0; din8 = 8'h00;
        e = 8'b11000101;
        for (int i = 0; i < 8; i++) begin
            chk("msb_so_valid", sv8, 1);
            chk("msb_so", so8, e[7-i]);
            chk("msb_so_last", sl8, i == 7);
            @(negedge clk);
        end
        chk("msb_end_valid", sv8, 0);
        chk("msb_end_busy", bsy8, 0);

        // loopback into the 4-bit SIPO
        din = 4'h9; lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        k = 0;
        while (!sl && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("loop_last_seen", sl, 1);
        @(negedge clk);
        chk("loop_q", q, 4'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
